// File: rtl/muldiv_hilo_unit.sv
// Iterative unsigned MULTU/DIVU unit holding the HI/LO registers.
// One result bit per cycle; HI/LO change only on the commit edge.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH:0]   prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, divisor_q, quo_q, quo_d, hi_q, lo_q;
  logic [WIDTH:0]     rem_q, rem_d, add_sum;
  logic [WIDTH+1:0]   rem_sh, rem_diff;
  logic               busy_q, done_q;
  logic               is_mul, is_div, last_iter;

  assign is_mul    = start && (alu_ctrl == 4'd7);
  assign is_div    = start && (alu_ctrl == 4'd8);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // One shift-add step and one restoring-divide step, evaluated every cycle.
  always_comb begin
    add_sum  = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_d   = {1'b0, add_sum, prod_q[WIDTH-1:1]};
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_diff = rem_sh - {2'b00, divisor_q};
    if (rem_diff[WIDTH+1]) begin
      rem_d = rem_sh[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = rem_diff[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (is_mul) begin
            mcand_q <= src_a;
            prod_q  <= {{(WIDTH+1){1'b0}}, src_b};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end else if (is_div) begin
            divisor_q <= src_b;
            quo_q     <= src_a;
            rem_q     <= '0;
            cnt_q     <= '0;
            // Divide by zero resolves immediately without iterating.
            if (src_b == '0) begin
              hi_q    <= src_a;
              lo_q    <= '1;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              busy_q  <= 1'b1;
              state_q <= DIV;
            end
          end
        end
        MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi_q    <= rem_d[WIDTH-1:0];
            lo_q    <= quo_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q && start && (alu_ctrl >= 4'd7) && (alu_ctrl <= 4'd10);
  assign mf_result = (alu_ctrl == 4'd9)  ? hi_q :
                     (alu_ctrl == 4'd10) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed-vector bench for muldiv_hilo_unit: timing, results, reset abort,
// busy collision and move-from behaviour.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, stall;
  logic [31:0] hi, lo, mf_result;

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .stall(stall),
    .hi(hi), .lo(lo), .mf_result(mf_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drive one issue cycle; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alu_ctrl = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 4'd0;
  endtask

  // From a sample point, count busy cycles and the sample index where done shows.
  task automatic wait_done(output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int n = 1; n <= 100; n++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy, input int exp_done,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bn, dn;
    issue(op, a, b);
    wait_done(bn, dn);
    check({tag, "_busy_cycles"}, 64'(bn), 64'(exp_busy));
    check({tag, "_done_at"}, 64'(dn), 64'(exp_done));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int bn, dn;
    logic done_seen, busy_seen;

    // Power-on reset
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul_ffff", 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 33, 32'hFFFF_FFFE, 32'h0000_0001);
    check("mf_other_code", 64'(mf_result), 64'd0);

    // Reset asserted at iteration 10 of a multiply aborts it
    issue(4'd7, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0; busy_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      done_seen |= done;
      busy_seen |= busy;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_no_busy", 64'(busy_seen), 64'd0);
    check("abort_hi_after", 64'(hi), 64'd0);

    run_op("div_100_7", 4'd8, 32'd100, 32'd7, 32, 33, 32'd2, 32'd14);
    run_op("div_5_9", 4'd8, 32'd5, 32'd9, 32, 33, 32'd5, 32'd0);
    run_op("div_max_1", 4'd8, 32'hFFFF_FFFF, 32'd1, 32, 33, 32'd0, 32'hFFFF_FFFF);
    run_op("div_zero", 4'd8, 32'hDEAD_BEEF, 32'd0, 0, 1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

    // Busy collision: DIVU during MULTU 3x4 is ignored
    issue(4'd7, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    #1;
    check("coll_hold_hi", 64'(hi), 64'hDEAD_BEEF);
    check("coll_hold_lo", 64'(lo), 64'hFFFF_FFFF);
    start = 1'b1; alu_ctrl = 4'd8; src_a = 32'd9; src_b = 32'd2;
    #1;
    check("coll_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 4'd0;
    wait_done(bn, dn);
    check("coll_done_at", 64'(dn), 64'd27);
    check("coll_hi", 64'(hi), 64'd0);
    check("coll_lo", 64'(lo), 64'd12);
    @(posedge clk); #1;
    check("coll_no_div", 64'(busy), 64'd0);

    // Move-from while busy stalls and sees the old value
    issue(4'd8, 32'd1000, 32'd7);
    start = 1'b1; alu_ctrl = 4'd10;
    #1;
    check("mf_busy_stall", 64'(stall), 64'd1);
    check("mf_busy_old_lo", 64'(mf_result), 64'd12);
    wait_done(bn, dn);
    check("mf_done_at", 64'(dn), 64'd33);
    check("mflo_new", 64'(mf_result), 64'd142);
    check("mflo_no_stall", 64'(stall), 64'd0);
    alu_ctrl = 4'd9;
    #1;
    check("mfhi_new", 64'(mf_result), 64'd6);
    check("mfhi_no_stall", 64'(stall), 64'd0);
    start = 1'b0; alu_ctrl = 4'd0;

    run_op("mul_by_zero", 4'd7, 32'h1234_5678, 32'd0, 32, 33, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative unsigned multiply/divide unit with the architectural HI/LO registers.
- Sits downstream of the control unit in the execute stage. It consumes alu_ctrl codes 7 (MULTU), 8 (DIVU), 9 (MFHI) and 10 (MFLO), plus the register-file operands rs and rt.
- Produces HI/LO, the move-from result, and a stall request back to the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue qualifier; the unit acts on alu_ctrl only when start=1.
- alu_ctrl  in  4  control-unit ALU code: 7=MULTU, 8=DIVU, 9=MFHI, 10=MFLO; all other codes are ignored.
- src_a  in  WIDTH  rs operand: multiplicand or dividend.
- src_b  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse after HI/LO commit.
- stall  out  1  pipeline hold request.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mf_result  out  WIDTH  move-from result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter=0; hi=lo=0; busy=done=0; all datapath registers=0. Reset asserted mid-operation aborts the operation with no commit.
- FSM states: IDLE, MUL, DIV, FIN.
- Accept: in IDLE, start=1 with alu_ctrl∈{7,8} latches src_a/src_b at edge E0 and clears the counter.
  - MULTU goes to MUL.
  - DIVU with src_b≠0 goes to DIV.
  - DIVU with src_b=0 commits hi=src_a, lo={WIDTH{1}} at E0 and goes to FIN.
- MUL: shift-add, one bit per cycle.
  - Product register is 2*WIDTH+1 bits, initialised {0, 0…0, src_b}.
  - Each cycle: if P[0]=1, add the multiplicand into P[2W:W]; then shift P right by 1.
- DIV: restoring division, one bit per cycle.
  - Remainder register is WIDTH+1 bits, quotient register is WIDTH bits.
  - Each cycle: shift {R,Q} left by 1; compute R−divisor; if the result is non-negative, keep it and set Q[0]=1, otherwise restore R.
- Counter increments every MUL/DIV cycle.
- On the WIDTH-th iteration edge (E_WIDTH), HI/LO commit and the FSM goes to FIN.
  - MULTU: hi=P[2W-1:W], lo=P[W-1:0].
  - DIVU: lo=quotient, hi=remainder.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. FIN also accepts a new start, which behaves identically to an accept from IDLE.
- Timing: busy=1 for exactly WIDTH cycles for MULTU and for DIVU with nonzero divisor. Latency from accept edge to done is WIDTH+1 cycles. Divide-by-zero has busy=0, with done in the cycle after E0.
- hi/lo hold their old values during an operation and change only at the commit edge.
- start with alu_ctrl∈{7,8} while busy=1 is ignored; it must never corrupt the in-flight operation. Upstream holds the instruction because stall=1.
- mf_result (combinational): hi if alu_ctrl=9, lo if alu_ctrl=10, 0 otherwise.
- stall (combinational): busy & start & alu_ctrl∈{7,8,9,10}. MFHI/MFLO issued during busy stalls until the commit is visible; the registered hi/lo are read in FIN.
- Arithmetic is unsigned throughout; no overflow exists (HI:LO holds the full 2*WIDTH-bit product).

Test Plan:
- Reset: assert rst_n=0 mid-MUL at iteration 10, then release → hi=lo=0, busy=0, done never pulses, state IDLE.
- MULTU: src_a=0xFFFFFFFF, src_b=0xFFFFFFFF → busy high 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse at cycle 33. Also src_a=0x12345678, src_b=0 → hi=lo=0.
- DIVU: src_a=100, src_b=7 → lo=14, hi=2 after 32 cycles. Also src_a=5, src_b=9 → lo=0, hi=5. Also src_a=0xFFFFFFFF, src_b=1 → lo=0xFFFFFFFF, hi=0.
- Divide by zero: src_a=0xDEADBEEF, src_b=0 → hi=0xDEADBEEF, lo=0xFFFFFFFF on the next edge, busy never high, done the following cycle.
- Busy collision: during MULTU 3×4, issue DIVU 9/2 at iteration 5 → stall=1, DIVU ignored, final hi=0, lo=12.
- Move-from: MFLO issued with start=1 while busy → stall=1, mf_result shows the old lo. After done, MFLO gives the new lo and MFHI gives the new hi, with stall=0.
